// File: rtl/addsub32_byte_sequencer.sv
// Byte-serial add/subtract: a single 8-bit adder walks NBYTES slices LSB-first with a chained carry; done pulses NBYTES+1 cycles after start.
// No backpressure: start is accepted in IDLE/DONE and ignored while busy. Signed overflow flag is built only with ADDSUB_SEQ_OVF_EN.
module addsub32_byte_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic                  zero,
    output logic                  ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;
    logic            zero_q, zero_d;

    logic [7:0]      a_byte;
    logic [7:0]      opnd_byte;
    logic [8:0]      slice_sum;
    logic            last_slice;

    // B is stored pre-inverted for subtract so the RUN datapath never looks at op_sub.
    assign a_byte     = a_q[{idx_q, 3'b000} +: 8];
    assign opnd_byte  = opnd_q[{idx_q, 3'b000} +: 8];
    assign slice_sum  = {1'b0, a_byte} + {1'b0, opnd_byte} + {8'b0, carry_q};
    assign last_slice = (idx_q == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    opnd_d  = op_sub ? ~b : b;
                    idx_d   = '0;
                    carry_d = op_sub;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                result_d[{idx_q, 3'b000} +: 8] = slice_sum[7:0];
                carry_d = slice_sum[8];
                if (last_slice) begin
                    idx_d   = '0;
                    cout_d  = slice_sum[8];
                    zero_d  = ~|result_d;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
        end
    end

`ifdef ADDSUB_SEQ_OVF_EN
    logic ovf_q;
    logic carry_into_msb;

    // Carry into bit 7 of the top slice recovered from the sum bit: s7 = a7 ^ b7 ^ c7.
    assign carry_into_msb = slice_sum[7] ^ a_byte[7] ^ opnd_byte[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last_slice) begin
            ovf_q <= carry_into_msb ^ slice_sum[8];
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_addsub32_byte_sequencer.sv
// Directed table-driven bench for addsub32_byte_sequencer plus back-to-back, ignored-start and mid-RUN reset sequences.
module tb_addsub32_byte_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        cout;
    logic        zero;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    addsub32_byte_sequencer #(.NBYTES(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sub;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp_res;
        logic        exp_cout;
        logic        exp_zero;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following the sampling edge.
    task automatic launch(input logic sub, input logic [31:0] va, input logic [31:0] vb);
        start  = 1'b1;
        op_sub = sub;
        a      = va;
        b      = vb;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (done !== 1'b1 && cnt < 20) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
            check("busy_done_excl", {31'b0, busy & done}, 32'd0);
        end
    endtask

    function automatic logic exp_ovf_of(input logic v);
`ifdef ADDSUB_SEQ_OVF_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    initial begin
        int cnt;
        int ndone;
        logic [31:0] seen;

        rst_n  = 1'b0;
        start  = 1'b0;
        op_sub = 1'b0;
        a      = '0;
        b      = '0;

        vecs[0] = '{1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h00000007, 32'h00000005, 32'h00000002, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 32'h12345678, 32'h9ABCDEF0, 32'hACF13568, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        check("reset_flags", {26'b0, busy, done, cout, zero, ovf, 1'b0}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_flags", {27'b0, busy, done, cout, zero, ovf}, 32'd0);
            check("idle_result", result, 32'd0);
        end

        for (int i = 0; i < 9; i++) begin
            launch(vecs[i].sub, vecs[i].va, vecs[i].vb);
            check("busy_after_start", {31'b0, busy}, 32'd1);
            wait_done(cnt);
            check("latency_edges", cnt, 32'd4);
            check("vec_result", result, vecs[i].exp_res);
            check("vec_cout", {31'b0, cout}, {31'b0, vecs[i].exp_cout});
            check("vec_zero", {31'b0, zero}, {31'b0, vecs[i].exp_zero});
            check("vec_ovf", {31'b0, ovf}, {31'b0, exp_ovf_of(vecs[i].exp_ovf)});
            @(posedge clk);
            @(negedge clk);
            check("done_one_cycle", {30'b0, busy, done}, 32'd0);
            check("result_held", result, vecs[i].exp_res);
        end

        // Back-to-back: second start presented during the DONE cycle.
        launch(1'b0, 32'h00000001, 32'h00000002);
        wait_done(cnt);
        check("b2b_first_result", result, 32'h00000003);
        launch(1'b1, 32'h0000000A, 32'h00000003);
        check("b2b_busy", {30'b0, busy, done}, 32'd2);
        check("b2b_result_held", result, 32'h00000003);
        wait_done(cnt);
        check("b2b_latency", cnt, 32'd4);
        check("b2b_result", result, 32'h00000007);
        check("b2b_cout", {31'b0, cout}, 32'd1);

        // start pulsed in RUN cycles 2 and 3 must be dropped.
        @(posedge clk);
        @(negedge clk);
        launch(1'b0, 32'h11111111, 32'h22222222);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 32'hFFFFFFFF;
        b     = 32'h0000FFFF;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        seen  = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                seen = result;
            end
        end
        check("ignore_done_count", ndone, 32'd1);
        check("ignore_result", seen, 32'h33333333);

        // Asynchronous reset in RUN cycle 2.
        launch(1'b0, 32'h01010101, 32'h01010101);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_flags", {27'b0, busy, done, cout, zero, ovf}, 32'd0);
        check("arst_result", result, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("arst_no_done", ndone, 32'd0);
        launch(1'b1, 32'd100, 32'd1);
        wait_done(cnt);
        check("post_rst_latency", cnt, 32'd4);
        check("post_rst_result", result, 32'd99);
        check("post_rst_cout", {31'b0, cout}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
